// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared types and constants for the MEM-stage access unit.
//   state_t     - access FSM states
//   F3_*        - funct3 access size/sign codes
//   WBH_*       - bit positions inside WB_Hazard_out
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WBH_REGWR = 0;
  localparam int WBH_LOAD  = 1;

endpackage

// File: rtl/mem_access_unit_align.sv
// mem_align: combinational byte-lane logic for data-memory accesses.
//   funct3     in  access size/sign
//   addr_lo    in  byte offset within the word
//   rdata      in  raw load word
//   store_data in  rs2 value
//   load_data  out extracted and extended load value
//   we         out store byte strobes
//   wdata      out store data replicated across lanes
//   misalign   out access not naturally aligned
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // halfword codes share funct3[1:0]=01 (signed and unsigned)
  assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3 == F3_W) && (addr_lo != 2'b00));

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    we    = 4'b1111;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        we    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        we    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        we    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//   clk/rst          clock, async active-high reset
//   Stall            downstream WB register holding
//   mem_valid, mem_read, mem_write, reg_write, funct3, alu_result, store_data
//                    MEM-stage instruction fields (stable while mem_busy)
//   dm_req/dm_we/dm_addr/dm_wdata   registered memory request
//   dm_ready/dm_rvalid/dm_rdata     memory handshake and load return
//   mem_busy         stall request to hazard unit
//   misalign         one-cycle pulse when a misaligned access is dropped
//   wb_data_out, WB_Hazard_out      values for the WB data register
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int addrWidth = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Stall,
  input  logic                 mem_valid,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  input  logic [2:0]           funct3,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          store_data,
  output logic                 dm_req,
  output logic [3:0]           dm_we,
  output logic [addrWidth-1:0] dm_addr,
  output logic [31:0]          dm_wdata,
  input  logic                 dm_ready,
  input  logic                 dm_rvalid,
  input  logic [31:0]          dm_rdata,
  output logic                 mem_busy,
  output logic                 misalign,
  output logic [31:0]          wb_data_out,
  output logic [1:0]           WB_Hazard_out
);

  state_t      state, state_nxt;
  logic        is_mem;
  logic        mis_c;
  logic [31:0] ld_c;
  logic [3:0]  we_c;
  logic [31:0] wd_c;
  logic        ld_q;
  logic [1:0]  hz_q;
  logic [31:0] cap_q;

  mem_align u_align (
    .funct3     (funct3),
    .addr_lo    (alu_result[1:0]),
    .rdata      (dm_rdata),
    .store_data (store_data),
    .load_data  (ld_c),
    .we         (we_c),
    .wdata      (wd_c),
    .misalign   (mis_c)
  );

  assign is_mem = mem_valid & (mem_read | mem_write);

  always_comb begin
    state_nxt     = state;
    mem_busy      = 1'b0;
    wb_data_out   = alu_result;
    WB_Hazard_out = '0;
    WB_Hazard_out[WBH_REGWR] = mem_valid & reg_write;
    case (state)
      S_IDLE: if (is_mem) begin
        mem_busy  = 1'b1;
        state_nxt = mis_c ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_busy = 1'b1;
        if (dm_ready) state_nxt = ld_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (dm_rvalid) state_nxt = S_DONE;
      end
      S_DONE: begin
        wb_data_out   = cap_q;
        WB_Hazard_out = hz_q;
        if (!Stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dm_req   <= 1'b0;
      dm_we    <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      misalign <= 1'b0;
      ld_q     <= 1'b0;
      hz_q     <= '0;
      cap_q    <= '0;
    end else begin
      state    <= state_nxt;
      dm_req   <= (state_nxt == S_REQ);
      misalign <= (state == S_IDLE) && is_mem && mis_c;
      if (state == S_IDLE && is_mem) begin
        // stores and dropped accesses report zero data
        ld_q  <= mem_read;
        cap_q <= '0;
        hz_q  <= '0;
        if (!mis_c && mem_read) begin
          hz_q[WBH_LOAD]  <= 1'b1;
          hz_q[WBH_REGWR] <= reg_write;
        end
        if (!mis_c) begin
          dm_addr  <= alu_result[addrWidth+1:2];
          dm_we    <= mem_write ? we_c : 4'b0000;
          dm_wdata <= wd_c;
        end
      end
      if (state == S_WAIT && dm_rvalid) cap_q <= ld_c;
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the 5-stage CPU, sitting directly upstream of the WB data stage register. It issues load/store requests to data memory over a ready/valid handshake and aligns and extends load data. It produces the write-back value and the WB hazard flags that the WB data register captures. While an access is outstanding it raises a stall request to the hazard unit.

## Interface
- addrWidth, 15, data-memory word-address width; `dm_addr` = `alu_result[addrWidth+1:2]`
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Stall  in  1  downstream stall; WB data register is holding and will not accept
- mem_valid  in  1  valid instruction present in MEM stage
- mem_read / mem_write  in  1 each  load / store instruction; never both high
- reg_write  in  1  instruction writes rd
- funct3  in  3  access size/sign (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- alu_result  in  32  effective address (memory ops) or result (others)
- store_data  in  32  rs2 value for stores
- dm_req  out  1  request valid, registered
- dm_we  out  4  byte write strobes; 0000 for loads
- dm_addr  out  addrWidth  word address
- dm_wdata  out  32  byte-lane-replicated store data
- dm_ready  in  1  memory accepts request this cycle
- dm_rvalid  in  1  load data valid; never in the same cycle as the accepting dm_ready
- dm_rdata  in  32  load word
- mem_busy  out  1  stall request to hazard unit
- misalign  out  1  one-cycle pulse: misaligned access dropped
- wb_data_out  out  32  value for WB data register
- WB_Hazard_out  out  2  bit0 = rd written, bit1 = value came from load

## Operation
- FSM states: IDLE, REQ, WAIT, DONE; encoding lives in the package.
- IDLE, non-memory op or `!mem_valid`:
  - `wb_data_out = alu_result`, `WB_Hazard_out = {0, mem_valid&reg_write}`, `mem_busy = 0`, combinational.
- IDLE, memory op, aligned:
  - `mem_busy = 1`; request fields are registered; next state REQ.
- Misaligned access:
  - Cases: LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - No request is issued. `misalign` pulses and the FSM goes to DONE with `wb_data_out = 0` and `WB_Hazard_out = 0`.
- REQ:
  - `dm_req = 1`; address, strobes and data are held stable until `dm_ready`.
  - On `dm_ready`: load → WAIT; store → DONE.
- WAIT:
  - On `dm_rvalid`, capture the aligned/extended `dm_rdata` → DONE.
- DONE:
  - `mem_busy = 0`; `wb_data_out` = captured load value (stores: 0).
  - `WB_Hazard_out = {1, reg_write}` for loads, `{0, 0}` for stores.
  - `Stall` high → stay in DONE with outputs held; low → IDLE.
- Load alignment: byte lane `addr[1:0]`, half lane `addr[1]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Store strobes: SB `0001<<addr[1:0]`, SH `0011<<{addr[1],0}`, SW `1111`. `dm_wdata` replicates the byte or halfword to all lanes.
- MEM-stage inputs must stay stable while `mem_busy = 1`; the unit does not re-sample them after IDLE.
- `dm_rvalid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `dm_req 0`, `dm_we 0`, `dm_addr 0`, `dm_wdata 0`, `misalign 0`, captured data 0. `mem_busy`, `wb_data_out` and `WB_Hazard_out` follow the IDLE combinational rules.
- `rst` mid-access (REQ/WAIT) aborts: `dm_req` drops immediately and any later response is ignored.
- Non-memory op: 0 added cycles.
- Load, `dm_ready` in the first REQ cycle, `dm_rvalid` the next cycle: `mem_busy` high for 3 cycles (IDLE, REQ, WAIT); result in cycle 4 (DONE).
- Store with immediate `dm_ready`: `mem_busy` high for 2 cycles; DONE in cycle 3.
- Each extra `dm_ready` or `dm_rvalid` wait cycle adds exactly one cycle.
- Misaligned access: 1 busy cycle, then DONE.

## Structure
- Shared package holds:
  - FSM state typedef
  - funct3 constants
  - `WB_Hazard` bit indices (WBH_REGWR=0, WBH_LOAD=1)
- Sub-module `mem_align`: combinational load extract/extend and store strobe/data generation, keyed by `funct3` and `addr[1:0]`.

## Test plan
- ADD result 0x1234_5678, `reg_write=1` → same-cycle `wb_data_out=0x12345678`, `WB_Hazard_out=01`, `mem_busy=0`.
- LB addr 0x103, `dm_rdata=0x80FF_0000`, immediate ready/rvalid → `dm_addr=0x40`, `dm_we=0000`; cycle 4 `wb_data_out=0xFFFFFF80`, `WB_Hazard_out=11`. Same sequence as LBU → `0x00000080`.
- SH addr 0x22, `store_data=0xABCD` → `dm_we=1100`, `dm_wdata=0xABCDABCD`; `dm_ready` held low 3 cycles → `mem_busy` high for 5 cycles total.
- LW addr 0x6 → no `dm_req`, `misalign` pulse, DONE with `wb_data_out=0` and `WB_Hazard_out=00`.
- LW completes while `Stall=1` for 2 cycles → DONE held and `wb_data_out` stable for 2 cycles; IDLE after `Stall` falls.
- `rst` asserted in WAIT, then `dm_rvalid` arrives → `dm_req=0`, state IDLE, response ignored, outputs at reset values.
